imem_fetch_ctrl: RTL and testbench
==================================

# imem_fetch_ctrl

Fetch sequencer that drives the synchronous instruction memory and feeds decode. It owns the PC, issues word reads at one per cycle, and absorbs the memory's one-cycle read latency with a 2-entry return buffer. Output to decode is a valid/ready stream, so decode back-pressure never loses an instruction. It sits between the core's branch/jump redirect logic and the block-RAM instruction memory.

## Interface

- XLEN, 32, address/PC width
- RESET_PC, 0, byte address fetched first after reset

- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- fetch_en  in  1  1 = issue new reads; 0 = hold PC, no new issues (in-flight data still returns)
- redirect_valid  in  1  single-cycle pulse: flush and restart at redirect_pc
- redirect_pc  in  XLEN  byte address of new fetch target
- mem_en  out  1  read strobe to instruction memory
- mem_addr  out  XLEN  byte address of the read (memory indexes by addr>>2)
- mem_rdata  in  32  read word, valid the cycle after mem_en
- instr_valid  out  1  instr_data/instr_pc hold a fetched instruction
- instr_ready  in  1  decode accepts when instr_valid & instr_ready
- instr_data  out  32  instruction word
- instr_pc  out  XLEN  byte address of instr_data
- fetch_fault  out  1  sticky misaligned-target flag (see Configuration)

## Operation

- State machine: BOOT -> RUN. BOOT lasts exactly one cycle after rst deasserts (mem_en=0), then RUN forever until reset.
- Registers: pc (next address to issue), inflight (1 bit: read issued last cycle), inflight_pc, kill (in-flight response to be discarded), 2-entry FIFO of {pc, word}.
- Issue condition in RUN: fetch_en & !fetch_fault & (fifo_count + inflight - pop < 2), pop = instr_valid & instr_ready. Issue => mem_en=1, mem_addr=pc, pc<=pc+4, inflight<=1, inflight_pc<=pc.
- Return: if inflight & !kill, push {inflight_pc, mem_rdata} into FIFO. Credit rule guarantees no overflow.
- Output: instr_valid = fifo_count!=0; instr_data/instr_pc = FIFO head. Pop on handshake.
- Redirect (priority over everything): FIFO cleared, current in-flight response marked kill, pc <= redirect_pc. In the redirect cycle mem_addr = redirect_pc and the issue condition uses fifo_count=0, inflight=0; if issued, pc <= redirect_pc+4. A pop in the redirect cycle is honoured (decode consumed the old head) but the entry is still flushed.
- pc addition wraps modulo 2^XLEN.
- fetch_en=0 mid-stream: no issue; the in-flight word still lands in the FIFO; outputs drain normally.
- Reset mid-operation: all state cleared immediately, in-flight data discarded, restart from RESET_PC.

## Timing

- Reset values: mem_en=0, mem_addr=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0, fetch_fault=0; pc=RESET_PC.
- First issue: first RUN cycle (2nd clk edge after rst release); first instr_valid two cycles later.
- Issue-to-instr_valid latency: 2 cycles (memory 1 + FIFO register 1).
- Redirect at cycle N with fetch_en=1: target issued at N, instr_valid with instr_pc=redirect_pc at N+2; nothing from the old path is valid at N+1 or later.
- Steady state with instr_ready=1: one instruction per cycle, no bubbles.
- instr_ready=0: at most 2 words buffered, then mem_en stays 0 until a pop; instr_data/instr_pc stable while instr_valid & !instr_ready.

## Configuration

- IMEM_FETCH_MISALIGN_EN defined: redirect with redirect_pc[1:0]!=0 flushes as normal but issues nothing, sets fetch_fault=1 (sticky); issue is blocked until a redirect with an aligned target clears it.
- Not defined: redirect_pc[1:0] forced to 2'b00; fetch_fault tied 0.

## Test plan

- Reset release, fetch_en=1, instr_ready=1, memory words 0..3 = fff00093, 00400113, 00112223, 00411203 -> instr_pc 0,4,8,12 on consecutive cycles starting 3 cycles after release, matching data.
- instr_ready=0 for 5 cycles after the first valid -> exactly 2 words buffered, mem_en low after buffer fills, resume gives pc 0,4,8 with none skipped or duplicated.
- redirect_valid with redirect_pc=0x40 while stream running at pc 0x10 -> next instr_pc seen is 0x40, two cycles after redirect, no 0x10/0x14 leakage.
- Redirect in the same cycle as a pop with FIFO full -> no stale output, target valid at N+2.
- IMEM_FETCH_MISALIGN_EN defined, redirect_pc=0x42 -> fetch_fault=1, mem_en=0, instr_valid=0; redirect to 0x80 -> fault clears, instr_pc=0x80. Macro undefined: same stimulus fetches 0x40.
- Assert rst while FIFO holds 2 entries -> all outputs at reset values immediately; restart from RESET_PC.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: fetch sequencer between redirect logic, synchronous imem and decode.
// Owns the PC, issues one word read per cycle, buffers returns in a 2-entry FIFO.
//
// Parameters:
//   XLEN      address / PC width
//   RESET_PC  first byte address fetched after reset
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   fetch_en                     allow new reads
//   redirect_valid, redirect_pc  flush and restart at redirect_pc
//   mem_en, mem_addr, mem_rdata  instruction memory read port (1-cycle latency)
//   instr_valid, instr_ready     valid/ready stream to decode
//   instr_data, instr_pc         fetched word and its byte address
//   fetch_fault                  sticky misaligned-redirect flag
// Build option:
//   IMEM_FETCH_MISALIGN_EN  misaligned redirect targets raise fetch_fault
//                           instead of being silently aligned down.

module imem_fetch_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_en,
    output logic [XLEN-1:0] mem_addr,
    input  logic [31:0]     mem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr_data,
    output logic [XLEN-1:0] instr_pc,
    output logic            fetch_fault
);

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            inflight;
    logic [XLEN-1:0] inflight_pc;
    logic [1:0]      fifo_count;
    logic [XLEN-1:0] head_pc;
    logic [31:0]     head_word;
    logic [XLEN-1:0] tail_pc;
    logic [31:0]     tail_word;

    logic [XLEN-1:0] target;
    logic            misaligned;
    logic            fault_now;
    logic            credit_ok;
    logic            issue;
    logic            pop;
    logic            push;
    logic            kill;

`ifdef IMEM_FETCH_MISALIGN_EN
    logic fault_q;

    assign target      = redirect_pc;
    assign misaligned  = redirect_valid & (redirect_pc[1:0] != 2'b00);
    assign fetch_fault = fault_q;
`else
    assign target      = redirect_pc & ~XLEN'(3);
    assign misaligned  = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    // A redirect decides the fault state for its own cycle, so an aligned
    // redirect can issue immediately even while the old fault is still set.
    assign fault_now = redirect_valid ? misaligned : fetch_fault;

    assign pop = instr_valid & instr_ready;

    // Slots already committed (buffered + returning) must leave room for
    // the word this issue will return; a redirect frees every slot.
    assign credit_ok = redirect_valid
                     | (({1'b0, fifo_count} + {2'b00, inflight})
                        < (3'd2 + {2'b00, pop}));

    assign issue    = (state == RUN) & fetch_en & ~fault_now & credit_ok;
    assign mem_en   = issue;
    assign mem_addr = redirect_valid ? target : pc;

    // The word arriving in a redirect cycle belongs to the old path.
    assign kill = redirect_valid;
    assign push = inflight & ~kill;

    assign instr_valid = (fifo_count != 2'd0);
    assign instr_data  = head_word;
    assign instr_pc    = head_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            fifo_count  <= 2'd0;
            head_pc     <= '0;
            head_word   <= '0;
            tail_pc     <= '0;
            tail_word   <= '0;
`ifdef IMEM_FETCH_MISALIGN_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            unique case (state)
                BOOT:    state <= RUN;
                RUN:     state <= RUN;
                default: state <= BOOT;
            endcase

            if (redirect_valid) begin
                pc <= issue ? target + XLEN'(4) : target;
            end else if (issue) begin
                pc <= pc + XLEN'(4);
            end

            inflight <= issue;
            if (issue) begin
                inflight_pc <= mem_addr;
            end

`ifdef IMEM_FETCH_MISALIGN_EN
            if (redirect_valid) begin
                fault_q <= misaligned;
            end
`endif

            if (redirect_valid) begin
                fifo_count <= 2'd0;
            end else begin
                unique case ({push, pop})
                    2'b11: begin
                        if (fifo_count == 2'd2) begin
                            head_pc   <= tail_pc;
                            head_word <= tail_word;
                            tail_pc   <= inflight_pc;
                            tail_word <= mem_rdata;
                        end else begin
                            head_pc   <= inflight_pc;
                            head_word <= mem_rdata;
                        end
                    end
                    2'b10: begin
                        if (fifo_count == 2'd0) begin
                            head_pc   <= inflight_pc;
                            head_word <= mem_rdata;
                        end else begin
                            tail_pc   <= inflight_pc;
                            tail_word <= mem_rdata;
                        end
                        fifo_count <= fifo_count + 2'd1;
                    end
                    2'b01: begin
                        head_pc    <= tail_pc;
                        head_word  <= tail_word;
                        fifo_count <= fifo_count - 2'd1;
                    end
                    default: begin
                        fifo_count <= fifo_count;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed and randomized checks of imem_fetch_ctrl
// against a synchronous memory model and an in-order stream reference.

module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mem [64];

    imem_fetch_ctrl #(
        .XLEN    (32),
        .RESET_PC(32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .mem_en        (mem_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return mem[a[7:2]];
    endfunction

    always @(posedge clk) begin
        if (mem_en) mem_rdata <= word_at(mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mem_en"}, {31'b0, mem_en}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
        chk({tag, "_data"}, instr_data, 32'h0);
        chk({tag, "_pc"}, instr_pc, 32'h0);
        chk({tag, "_fault"}, {31'b0, fetch_fault}, 32'd0);
    endtask

    // Asserts reset at the current time, checks outputs right away,
    // then releases #1 after a rising edge.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        chk_reset_vals(tag);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic sample_head(input string tag, input logic [31:0] pcv);
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
        chk({tag, "_pc"}, instr_pc, pcv);
        chk({tag, "_data"}, instr_data, word_at(pcv));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prog [4];
        logic [31:0] exp_pc;
        logic        r1_v, r1_fe, r2_v, r2_fe;
        logic [31:0] r1_t, r2_t;
        logic        prev_stall;
        logic [31:0] prev_pc, prev_data;
        bit          hit;

        prog[0] = 32'hfff00093;
        prog[1] = 32'h00400113;
        prog[2] = 32'h00112223;
        prog[3] = 32'h00411203;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[i] = prog[i];

        rst            = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals("por");

        // Startup stream
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("boot_mem_en", {31'b0, mem_en}, 32'd0);
        @(negedge clk);
        chk("k1_mem_en", {31'b0, mem_en}, 32'd1);
        chk("k1_addr", mem_addr, 32'h0);
        chk("k1_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        chk("k2_addr", mem_addr, 32'h4);
        chk("k2_valid", {31'b0, instr_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sample_head("start", 32'(i * 4));
            chk("start_word", instr_data, prog[i]);
        end

        // Back-pressure from the first valid
        @(negedge clk);
        instr_ready = 1'b0;
        do_reset("rst2");
        @(negedge clk);
        @(negedge clk);
        chk("bp_k1_mem_en", {31'b0, mem_en}, 32'd1);
        @(negedge clk);
        chk("bp_k2_addr", mem_addr, 32'h4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sample_head("bp_hold", 32'h0);
            chk("bp_mem_en", {31'b0, mem_en}, 32'd0);
        end
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sample_head("bp_resume", 32'(i * 4));
        end

        // Redirect while stream running at 0x10
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (instr_valid && instr_pc == 32'h10) hit = 1'b1;
        end
        chk("rd_reach_10", {31'b0, hit}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        #1;
        chk("rd_mem_en", {31'b0, mem_en}, 32'd1);
        chk("rd_addr", mem_addr, 32'h40);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("rd_n1_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        sample_head("rd_n2", 32'h40);
        @(negedge clk);
        sample_head("rd_n3", 32'h44);

        // Redirect together with a pop while the FIFO is full
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("full_valid", {31'b0, instr_valid}, 32'd1);
        chk("full_mem_en", {31'b0, mem_en}, 32'd0);
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        #1;
        chk("rdpop_valid", {31'b0, instr_valid}, 32'd1);
        chk("rdpop_addr", mem_addr, 32'h80);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("rdpop_n1_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        sample_head("rdpop_n2", 32'h80);

        // Misaligned redirect
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        @(negedge clk);
`ifdef IMEM_FETCH_MISALIGN_EN
        chk("mis_mem_en", {31'b0, mem_en}, 32'd0);
`else
        chk("mis_mem_en", {31'b0, mem_en}, 32'd1);
        chk("mis_addr", mem_addr, 32'h40);
`endif
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("mis_n1_valid", {31'b0, instr_valid}, 32'd0);
`ifdef IMEM_FETCH_MISALIGN_EN
        chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
        @(negedge clk);
        chk("mis_n2_valid", {31'b0, instr_valid}, 32'd0);
        chk("mis_n2_mem_en", {31'b0, mem_en}, 32'd0);
        chk("mis_n2_fault", {31'b0, fetch_fault}, 32'd1);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        @(negedge clk);
        chk("fix_mem_en", {31'b0, mem_en}, 32'd1);
        chk("fix_addr", mem_addr, 32'h80);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("fix_fault", {31'b0, fetch_fault}, 32'd0);
        chk("fix_n1_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        sample_head("fix_n2", 32'h80);
`else
        chk("mis_fault", {31'b0, fetch_fault}, 32'd0);
        @(negedge clk);
        sample_head("mis_n2", 32'h40);
`endif

        // Reset while the FIFO holds two words
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
        instr_ready = 1'b1;
        do_reset("rst_mid");
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("rst_mid_k2_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        sample_head("rst_mid_k3", 32'h0);

        // Randomized traffic against an in-order stream reference
        @(negedge clk);
        instr_ready = 1'b0;
        do_reset("rst_rand");
        @(negedge clk);
        @(negedge clk);
        exp_pc     = 32'h0;
        r1_v       = 1'b0;
        r1_fe      = 1'b0;
        r1_t       = '0;
        r2_v       = 1'b0;
        r2_fe      = 1'b0;
        r2_t       = '0;
        prev_stall = 1'b0;
        prev_pc    = '0;
        prev_data  = '0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            fetch_en       = ($urandom_range(0, 9) != 0);
            instr_ready    = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            @(negedge clk);
            if (r1_v) begin
                chk("rnd_flush_n1", {31'b0, instr_valid}, 32'd0);
            end else if (r2_v && r2_fe) begin
                chk("rnd_tgt_valid", {31'b0, instr_valid}, 32'd1);
                chk("rnd_tgt_pc", instr_pc, r2_t);
            end
            if (prev_stall && !r1_v) begin
                chk("rnd_hold_valid", {31'b0, instr_valid}, 32'd1);
                chk("rnd_hold_pc", instr_pc, prev_pc);
                chk("rnd_hold_data", instr_data, prev_data);
            end
            if (instr_valid && instr_ready) begin
                chk("rnd_pc", instr_pc, exp_pc);
                chk("rnd_data", instr_data, word_at(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) exp_pc = redirect_pc;
            r2_v       = r1_v;
            r2_fe      = r1_fe;
            r2_t       = r1_t;
            r1_v       = redirect_valid;
            r1_fe      = fetch_en;
            r1_t       = redirect_pc;
            prev_stall = instr_valid & ~instr_ready;
            prev_pc    = instr_pc;
            prev_data  = instr_data;
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
